// File: rtl/surf_uart_pkg.sv
// surf_uart_pkg: shared types and constants for the surface-result UART reporter.
//   tx_state_t        : bit-timing FSM states used by uart_tx_byte
//   FRAME_BYTES       : bytes per frame (sync + 4 data [+ checksum])
//   SYNC_BYTE_DEFAULT : default first byte of every frame
// Build option: define SURF_UART_CHECKSUM_EN to append the XOR checksum byte.
package surf_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

`ifdef SURF_UART_CHECKSUM_EN
  localparam logic [2:0] FRAME_BYTES = 3'd6;

  // XOR of the four data bytes; the sync byte is deliberately not included.
  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction
`else
  localparam logic [2:0] FRAME_BYTES = 3'd5;
`endif

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser, LSB first, CLKS_PER_BIT cycles per bit.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   byte_valid : byte_in is offered this cycle
//   byte_in    : byte to send
//   byte_ready : a byte can be accepted this cycle (idle, or last stop cycle)
//   tx         : registered serial line, idle high
//
// state    | meaning
// ST_IDLE  | line idle high, waiting for a byte
// ST_START | start bit (tx=0)
// ST_DATA  | 8 data bits, LSB first
// ST_STOP  | stop bit (tx=1); a byte offered in its last cycle chains with no gap
module uart_tx_byte
  import surf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  output logic       byte_ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Ready in the final stop-bit cycle lets the next start bit follow directly.
  assign byte_ready = (state == ST_IDLE) || ((state == ST_STOP) && (cnt == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (byte_valid && byte_ready) begin
      state   <= ST_START;
      cnt     <= CNT_LOAD;
      bit_idx <= '0;
      shreg   <= byte_in;
      tx      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= 1'b1;
        end
        ST_START: begin
          if (cnt == '0) begin
            state <= ST_DATA;
            cnt   <= CNT_LOAD;
            tx    <= shreg[0];
            shreg <= {1'b0, shreg[7:1]};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            cnt <= CNT_LOAD;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/surf_uart_reporter.sv
// surf_uart_reporter: sends each completed surface word off-chip as a UART frame
// (sync byte, din[31:24], din[23:16], din[15:8], din[7:0] [, XOR checksum]).
//   clk     : system clock
//   rst     : synchronous active-high reset (aborts any frame)
//   start   : one-cycle frame request, accepted only when not busy
//   din     : 32-bit value, sampled on acceptance
//   tx      : registered UART line, idle high
//   busy    : frame in progress
//   done    : one-cycle pulse when a frame completes
//   overrun : sticky, set by start while busy; cleared only by rst
// Build option: SURF_UART_CHECKSUM_EN adds the trailing checksum byte.
module surf_uart_reporter
  import surf_uart_pkg::*;
#(
  parameter int         CLK_FREQ_HZ  = 100_000_000,
  parameter int         BAUD         = 115200,
  parameter int         CLKS_PER_BIT = CLK_FREQ_HZ / BAUD,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] din,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  logic [31:0] shreg;
  logic [2:0]  byte_idx;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_in;
`ifdef SURF_UART_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // While idle the sync byte is offered straight from start, so the start bit
  // appears the cycle after acceptance. byte_idx counts bytes already handed over.
  always_comb begin
    byte_valid = busy ? (byte_idx != FRAME_BYTES) : start;
    byte_in    = SYNC_BYTE;
    if (busy) begin
      byte_in = shreg[31:24];
`ifdef SURF_UART_CHECKSUM_EN
      if (byte_idx == FRAME_BYTES - 3'd1) begin
        byte_in = csum;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      byte_idx <= '0;
      shreg    <= '0;
`ifdef SURF_UART_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (start && busy) begin
        overrun <= 1'b1;
      end
      if (!busy) begin
        if (start) begin
          busy     <= 1'b1;
          byte_idx <= 3'd1;
          shreg    <= din;
`ifdef SURF_UART_CHECKSUM_EN
          csum     <= xor_bytes(din);
`endif
        end
      end else if (byte_ready) begin
        // byte_ready while busy means the current stop bit is in its last cycle.
        if (byte_idx == FRAME_BYTES) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          byte_idx <= '0;
        end else begin
          byte_idx <= byte_idx + 3'd1;
          shreg    <= {shreg[23:0], 8'h00};
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk       (clk),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_in   (byte_in),
    .byte_ready(byte_ready),
    .tx        (tx)
  );

endmodule

// File: tb/tb_surf_uart_reporter.sv
module tb_surf_uart_reporter;

  localparam int CPB = 4;
`ifdef SURF_UART_CHECKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int F = 10 * NB * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] din;
  logic        tx, busy, done, overrun;

  int vec = 0;
  int err = 0;

  surf_uart_reporter #(
    .CLK_FREQ_HZ(400),
    .BAUD       (100)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .din    (din),
    .tx     (tx),
    .busy   (busy),
    .done   (done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame of d (or continues one already requested when pre_started)
  // and checks bit timing, bytes, busy and done. ovr_at>0 injects a second start
  // at that cycle offset; scramble randomises din during the frame; chain leaves
  // start raised with d_next in the done cycle.
  task automatic run_frame(input logic [31:0] d, input bit pre_started, input int ovr_at,
                           input bit scramble, input bit chain, input logic [31:0] d_next,
                           input string name);
    logic [7:0] exp_b[6];
    logic       bits[60];
    logic [7:0] got;
    int         bad_busy, bad_done, bad_frame;
    exp_b[0] = 8'hA5;
    exp_b[1] = d[31:24];
    exp_b[2] = d[23:16];
    exp_b[3] = d[15:8];
    exp_b[4] = d[7:0];
    exp_b[5] = d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
    bad_busy = 0; bad_done = 0; bad_frame = 0;
    if (!pre_started) begin
      din   = d;
      start = 1'b1;
    end
    step();
    start = 1'b0;
    vec++;
    if (tx !== 1'b0) begin
      err++;
      $display("FAIL %s first_start_bit: tx=%b required 0", name, tx);
    end
    for (int c = 1; c <= F; c++) begin
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0) bad_done++;
      if ((c - 1) % CPB == 1) bits[(c - 1) / CPB] = tx;
      if (ovr_at > 0 && c == ovr_at + 1) begin
        vec++;
        if (overrun !== 1'b1) begin
          err++;
          $display("FAIL %s overrun_set: overrun=%b required 1", name, overrun);
        end
        start = 1'b0;
      end
      if (ovr_at > 0 && c == ovr_at) begin
        vec++;
        if (overrun !== 1'b0) begin
          err++;
          $display("FAIL %s overrun_pre: overrun=%b required 0", name, overrun);
        end
        start = 1'b1;
        din   = ~d;
      end
      if (scramble) din = $urandom();
      step();
    end
    vec++;
    if (bad_busy != 0) begin
      err++;
      $display("FAIL %s busy_window: %0d cycles low, required 0", name, bad_busy);
    end
    vec++;
    if (bad_done != 0) begin
      err++;
      $display("FAIL %s done_early: %0d cycles high, required 0", name, bad_done);
    end
    for (int k = 0; k < NB; k++) begin
      if (bits[10 * k] !== 1'b0 || bits[10 * k + 9] !== 1'b1) bad_frame++;
      for (int i = 0; i < 8; i++) got[i] = bits[10 * k + 1 + i];
      vec++;
      if (got !== exp_b[k]) begin
        err++;
        $display("FAIL %s byte%0d: got %02h required %02h", name, k, got, exp_b[k]);
      end
    end
    vec++;
    if (bad_frame != 0) begin
      err++;
      $display("FAIL %s framing: %0d bad start/stop bits, required 0", name, bad_frame);
    end
    vec++;
    if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      err++;
      $display("FAIL %s end_of_frame: done=%b busy=%b tx=%b required 1 0 1", name, done, busy, tx);
    end
    if (chain) begin
      din   = d_next;
      start = 1'b1;
    end else begin
      step();
      vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        err++;
        $display("FAIL %s done_pulse: done=%b busy=%b required 0 0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; din = '0;
    step(); step(); step();
    vec++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      err++;
      $display("FAIL reset_values: tx=%b busy=%b done=%b overrun=%b required 1 0 0 0",
               tx, busy, done, overrun);
    end
    rst = 1'b0;
    step(); step();
  endtask

  task automatic test_basic();
    run_frame(32'h12345678, 1'b0, 0, 1'b0, 1'b0, 32'h0, "basic");
    step(); step();
    run_frame(32'h80C3_5A01, 1'b0, 0, 1'b0, 1'b0, 32'h0, "pattern");
  endtask

  task automatic test_din_change();
    step();
    run_frame(32'hDEADBEEF, 1'b0, 0, 1'b1, 1'b0, 32'h0, "din_change");
  endtask

  task automatic test_overrun();
    step();
    run_frame(32'h12345678, 1'b0, 50, 1'b0, 1'b0, 32'h0, "overrun");
    vec++;
    if (overrun !== 1'b1) begin
      err++;
      $display("FAIL overrun_sticky: overrun=%b required 1", overrun);
    end
  endtask

  task automatic test_rst_mid_frame();
    int bad;
    step();
    din = 32'hCAFEBABE; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 100; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vec++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
      err++;
      $display("FAIL rst_abort: tx=%b busy=%b done=%b overrun=%b required 1 0 0 0",
               tx, busy, done, overrun);
    end
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
      step();
    end
    vec++;
    if (bad != 0) begin
      err++;
      $display("FAIL rst_quiet: %0d active cycles after abort, required 0", bad);
    end
    run_frame(32'h0BADF00D, 1'b0, 0, 1'b0, 1'b0, 32'h0, "after_rst");
  endtask

  task automatic test_back_to_back();
    step();
    run_frame(32'h1234ABCD, 1'b0, 0, 1'b0, 1'b1, 32'hFFFFFFFF, "b2b_first");
    run_frame(32'hFFFFFFFF, 1'b1, 0, 1'b0, 1'b0, 32'h0, "b2b_second");
    vec++;
    if (overrun !== 1'b0) begin
      err++;
      $display("FAIL b2b_no_overrun: overrun=%b required 0", overrun);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_din_change();
    test_overrun();
    test_rst_mid_frame();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
